// File: rtl/rb_param.sv
// rtl/rb_param.sv - parametrised register bank with byte-strobed bit-op writes and registered read port
module rb_param #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk_reg,
    input  logic                         rst,
    input  logic                         valid_reg,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            data_in,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic [1:0]                   wr_op,
    output logic                         wr_err,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_rsp_valid,
    input  logic                         rd_rsp_ready,
    output logic [DATA_W-1:0]            rd_rsp_data,
    output logic                         rd_rsp_err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          changed
);

    localparam int NUM_BYTES = DATA_W / 8;
    // Register count widened by one bit so it is representable even when NUM_REGS is a power of two.
    localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] nxt  [NUM_REGS];
    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_mux;

    function automatic logic [DATA_W-1:0] apply_op(
        input logic [DATA_W-1:0]    old_v,
        input logic [DATA_W-1:0]    din,
        input logic [NUM_BYTES-1:0] strb,
        input logic [1:0]           op
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (strb[b]) begin
                case (op_t'(op))
                    OP_WRITE:  res[b*8 +: 8] = din[b*8 +: 8];
                    OP_SET:    res[b*8 +: 8] = old_v[b*8 +: 8] | din[b*8 +: 8];
                    OP_CLEAR:  res[b*8 +: 8] = old_v[b*8 +: 8] & ~din[b*8 +: 8];
                    OP_TOGGLE: res[b*8 +: 8] = old_v[b*8 +: 8] ^ din[b*8 +: 8];
                    default:   res[b*8 +: 8] = old_v[b*8 +: 8];
                endcase
            end
        end
        return res;
    endfunction

    assign wr_in_range  = {1'b0, addr} < REG_COUNT;
    assign rd_in_range  = {1'b0, rd_addr} < REG_COUNT;
    assign rd_req_ready = ~rd_rsp_valid | rd_rsp_ready;
    assign rd_accept    = rd_req_valid & rd_req_ready;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            nxt[i] = regs[i];
            if (valid_reg && wr_in_range && addr == ADDR_W'(i)) begin
                nxt[i] = apply_op(regs[i], data_in, wstrb, wr_op);
            end
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    // Read samples the pre-write array, giving read-before-write on address collisions.
    always_ff @(posedge clk_reg) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            changed      <= '0;
            wr_err       <= 1'b0;
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
            rd_rsp_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]    <= nxt[i];
                changed[i] <= (nxt[i] != regs[i]);
            end
            wr_err <= valid_reg & ~wr_in_range;
            if (rd_accept) begin
                rd_rsp_valid <= 1'b1;
                rd_rsp_data  <= rd_in_range ? rd_mux : '0;
                rd_rsp_err   <= ~rd_in_range;
            end else if (rd_rsp_ready) begin
                rd_rsp_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_rb_param.sv
// tb/tb_rb_param.sv - directed table-driven bench for rb_param (4-reg and 5-reg instances)
module tb_rb_param;

    logic        clk;
    logic        rst;

    logic        valid_reg;
    logic [1:0]  addr;
    logic [15:0] data_in;
    logic [1:0]  wstrb;
    logic [1:0]  wr_op;
    logic        wr_err;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [1:0]  rd_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [15:0] rd_rsp_data;
    logic        rd_rsp_err;
    logic [63:0] regs_out;
    logic [3:0]  changed;

    logic        b_valid_reg;
    logic [2:0]  b_addr;
    logic [15:0] b_data_in;
    logic [1:0]  b_wstrb;
    logic [1:0]  b_wr_op;
    logic        b_wr_err;
    logic        b_rd_req_valid;
    logic        b_rd_req_ready;
    logic [2:0]  b_rd_addr;
    logic        b_rd_rsp_valid;
    logic        b_rd_rsp_ready;
    logic [15:0] b_rd_rsp_data;
    logic        b_rd_rsp_err;
    logic [79:0] b_regs_out;
    logic [4:0]  b_changed;

    int n_chk = 0;
    int n_fail = 0;

    rb_param #(.NUM_REGS(4), .DATA_W(16)) u_dut (
        .clk_reg(clk), .rst(rst), .valid_reg(valid_reg), .addr(addr), .data_in(data_in),
        .wstrb(wstrb), .wr_op(wr_op), .wr_err(wr_err), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_addr(rd_addr), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
        .regs_out(regs_out), .changed(changed)
    );

    rb_param #(.NUM_REGS(5), .DATA_W(16)) u_dut5 (
        .clk_reg(clk), .rst(rst), .valid_reg(b_valid_reg), .addr(b_addr), .data_in(b_data_in),
        .wstrb(b_wstrb), .wr_op(b_wr_op), .wr_err(b_wr_err), .rd_req_valid(b_rd_req_valid),
        .rd_req_ready(b_rd_req_ready), .rd_addr(b_rd_addr), .rd_rsp_valid(b_rd_rsp_valid),
        .rd_rsp_ready(b_rd_rsp_ready), .rd_rsp_data(b_rd_rsp_data), .rd_rsp_err(b_rd_rsp_err),
        .regs_out(b_regs_out), .changed(b_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [15:0] d;
        logic [1:0]  s;
        logic [1:0]  op;
        logic [15:0] exp_val;
        logic [3:0]  exp_chg;
    } wvec_t;

    wvec_t wv [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        wv[0] = '{2'd2, 16'hA5C3, 2'b11, 2'b00, 16'hA5C3, 4'b0100};
        wv[1] = '{2'd2, 16'h0F00, 2'b11, 2'b01, 16'hAFC3, 4'b0100};
        wv[2] = '{2'd2, 16'h0003, 2'b11, 2'b10, 16'hAFC0, 4'b0100};
        wv[3] = '{2'd2, 16'hFFFF, 2'b01, 2'b11, 16'hAF3F, 4'b0100};
        wv[4] = '{2'd1, 16'h1234, 2'b11, 2'b00, 16'h1234, 4'b0010};
        wv[5] = '{2'd1, 16'h1234, 2'b11, 2'b00, 16'h1234, 4'b0000};
        wv[6] = '{2'd1, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 4'b0000};
        wv[7] = '{2'd2, 16'h0F00, 2'b11, 2'b01, 16'hAF3F, 4'b0000};
        wv[8] = '{2'd0, 16'hABCD, 2'b10, 2'b00, 16'hAB00, 4'b0001};
        wv[9] = '{2'd3, 16'h1111, 2'b11, 2'b00, 16'h1111, 4'b1000};

        valid_reg = 0; addr = 0; data_in = 0; wstrb = 0; wr_op = 0;
        rd_req_valid = 0; rd_addr = 0; rd_rsp_ready = 1;
        b_valid_reg = 0; b_addr = 0; b_data_in = 0; b_wstrb = 0; b_wr_op = 0;
        b_rd_req_valid = 0; b_rd_addr = 0; b_rd_rsp_ready = 1;

        // Reset, with a write presented during the reset cycle that must be ignored
        rst = 1;
        step();
        valid_reg = 1; addr = 2'd1; data_in = 16'hFFFF; wstrb = 2'b11;
        step();
        rst = 0; valid_reg = 0;
        chk("reset_regs_out", regs_out, 64'h0);
        chk("reset_changed", changed, 4'h0);
        chk("reset_wr_err", wr_err, 1'b0);
        chk("reset_rsp_valid", rd_rsp_valid, 1'b0);
        chk("reset_rsp_data", rd_rsp_data, 16'h0);
        chk("reset_rsp_err", rd_rsp_err, 1'b0);

        for (int a = 0; a < 4; a++) begin
            rd_req_valid = 1; rd_addr = 2'(a);
            #1;
            chk("rd_req_ready_b2b", rd_req_ready, 1'b1);
            step();
            chk("reset_read_valid", rd_rsp_valid, 1'b1);
            chk("reset_read_data", rd_rsp_data, 16'h0);
            chk("reset_read_err", rd_rsp_err, 1'b0);
        end
        rd_req_valid = 0;
        step();
        chk("read_drain_valid", rd_rsp_valid, 1'b0);

        for (int i = 0; i < 10; i++) begin
            valid_reg = 1; addr = wv[i].a; data_in = wv[i].d; wstrb = wv[i].s; wr_op = wv[i].op;
            step();
            chk($sformatf("wr%0d_val", i), regs_out[wv[i].a*16 +: 16], wv[i].exp_val);
            chk($sformatf("wr%0d_changed", i), changed, wv[i].exp_chg);
            chk($sformatf("wr%0d_wr_err", i), wr_err, 1'b0);
        end
        valid_reg = 0;
        step();
        chk("idle_changed", changed, 4'h0);
        chk("all_regs", regs_out, 64'h1111_AF3F_1234_AB00);

        // Stalled response held across a write to the same register
        rd_req_valid = 1; rd_addr = 2'd0; rd_rsp_ready = 0;
        step();
        rd_req_valid = 0;
        chk("stall_first_valid", rd_rsp_valid, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                valid_reg = 1; addr = 2'd0; data_in = 16'hBEEF; wstrb = 2'b11; wr_op = 2'b00;
            end
            step();
            valid_reg = 0;
            chk("stall_valid", rd_rsp_valid, 1'b1);
            chk("stall_data", rd_rsp_data, 16'hAB00);
            chk("stall_err", rd_rsp_err, 1'b0);
            chk("stall_req_ready", rd_req_ready, 1'b0);
        end
        chk("stall_reg0_written", regs_out[15:0], 16'hBEEF);
        rd_rsp_ready = 1; rd_req_valid = 1; rd_addr = 2'd0;
        #1;
        chk("release_req_ready", rd_req_ready, 1'b1);
        step();
        chk("after_stall_data", rd_rsp_data, 16'hBEEF);
        rd_req_valid = 0;

        // Same-cycle write and read of reg3
        valid_reg = 1; addr = 2'd3; data_in = 16'h5555; wstrb = 2'b11; wr_op = 2'b00;
        rd_req_valid = 1; rd_addr = 2'd3;
        step();
        valid_reg = 0;
        chk("rbw_old_data", rd_rsp_data, 16'h1111);
        chk("rbw_reg3_new", regs_out[63:48], 16'h5555);
        chk("rbw_changed", changed, 4'b1000);
        step();
        rd_req_valid = 0;
        chk("rbw_next_read", rd_rsp_data, 16'h5555);
        step();
        chk("rbw_drain_valid", rd_rsp_valid, 1'b0);

        // Five-register instance: out-of-range write and read
        b_valid_reg = 1; b_addr = 3'd6; b_data_in = 16'hFFFF; b_wstrb = 2'b11; b_wr_op = 2'b00;
        step();
        chk("oor_wr_err", b_wr_err, 1'b1);
        chk("oor_regs", b_regs_out, 80'h0);
        chk("oor_changed", b_changed, 5'h0);
        b_addr = 3'd4; b_data_in = 16'h4444;
        step();
        b_valid_reg = 0;
        chk("inr_wr_err", b_wr_err, 1'b0);
        chk("reg4_val", b_regs_out[79:64], 16'h4444);
        chk("reg4_changed", b_changed, 5'b10000);
        b_rd_req_valid = 1; b_rd_addr = 3'd7;
        step();
        chk("oor_rd_valid", b_rd_rsp_valid, 1'b1);
        chk("oor_rd_err", b_rd_rsp_err, 1'b1);
        chk("oor_rd_data", b_rd_rsp_data, 16'h0);
        b_rd_addr = 3'd4;
        step();
        b_rd_req_valid = 0;
        chk("reg4_rd_err", b_rd_rsp_err, 1'b0);
        chk("reg4_rd_data", b_rd_rsp_data, 16'h4444);

        // Reset while a response is stalled
        rd_req_valid = 1; rd_addr = 2'd2; rd_rsp_ready = 0;
        step();
        rd_req_valid = 0;
        chk("pre_rst_data", rd_rsp_data, 16'hAF3F);
        step();
        chk("pre_rst_valid", rd_rsp_valid, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk("rst_stall_valid", rd_rsp_valid, 1'b0);
        chk("rst_stall_data", rd_rsp_data, 16'h0);
        chk("rst_regs", regs_out, 64'h0);
        chk("rst_changed", changed, 4'h0);
        chk("rst_b_regs", b_regs_out, 80'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
